// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: serialises core/debug CSR requests into a fixed
// IDLE -> READ -> WRITE -> RESP read-modify-write sequence.
// Optional feature macro: CSR_CTRL_DEBUG_PORT_EN (enables the debug requester
// and round-robin arbitration; when undefined the dbg_* ports are inert).
module csr_access_ctrl #(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  input  logic              core_valid_i,
  output logic              core_ready_o,
  input  logic [1:0]        core_op_i,
  input  logic [11:0]       core_addr_i,
  input  logic [C_XLEN-1:0] core_wdata_i,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic [1:0]        dbg_op_i,
  input  logic [11:0]       dbg_addr_i,
  input  logic [C_XLEN-1:0] dbg_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_src_o,
  output logic [C_XLEN-1:0] rsp_rdata_o,
  output logic              rsp_exc_o,
  output logic              csr_rd_o,
  output logic [11:0]       csr_rd_addr_o,
  input  logic [C_XLEN-1:0] csr_rd_data_i,
  output logic              csr_wr_o,
  output logic [11:0]       csr_wr_addr_o,
  output logic [C_XLEN-1:0] csr_wr_data_o,
  input  logic              csr_illegal_rd_i,
  input  logic              csr_illegal_wr_i
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic              src_q;
  logic [1:0]        op_q;
  logic [11:0]       addr_q;
  logic [C_XLEN-1:0] wdata_q;
  logic [C_XLEN-1:0] old_q;
  logic              rd_ill_q;
  logic              last_dbg_q;

  logic              dbg_valid_eff;
  logic              grant_dbg;
  logic              grant_core;
  logic              can_accept;
  logic              accept;
  logic              wr_req;
  logic              exc_nxt;
  logic [C_XLEN-1:0] wr_val;

`ifdef CSR_CTRL_DEBUG_PORT_EN
  assign dbg_valid_eff = dbg_valid_i;
`else
  // Debug requester is never granted; the data mux below still references
  // the dbg_* inputs so the port list stays identical in both builds.
  logic unused_dbg_valid;
  assign unused_dbg_valid = dbg_valid_i;
  assign dbg_valid_eff    = 1'b0;
`endif

  // Round-robin: on contention the requester not served last wins.
  assign grant_dbg  = dbg_valid_eff & (~core_valid_i | ~last_dbg_q);
  assign grant_core = core_valid_i & ~grant_dbg;

  assign can_accept   = (state == S_IDLE) & clk_en_i & ~reset_i;
  assign core_ready_o = can_accept & grant_core;
  assign dbg_ready_o  = can_accept & grant_dbg;
  assign accept       = core_ready_o | dbg_ready_o;

  // Set/clear with an all-zero mask is a no-op and must not touch the CSR.
  assign wr_req  = (op_q != OP_RD) &
                   ~(((op_q == OP_RS) | (op_q == OP_RC)) & (wdata_q == '0));
  assign exc_nxt = rd_ill_q | (wr_req & csr_illegal_wr_i);

  assign csr_rd_o      = (state == S_READ) & clk_en_i & ~reset_i;
  assign csr_wr_o      = (state == S_WRITE) & clk_en_i & ~reset_i &
                         wr_req & ~rd_ill_q & ~csr_illegal_wr_i;
  assign csr_rd_addr_o = addr_q;
  assign csr_wr_addr_o = addr_q;
  assign csr_wr_data_o = wr_val;

  // New CSR value from the captured old value and the latched operand.
  always_comb begin
    wr_val = old_q;
    unique case (op_q)
      OP_RW:   wr_val = wdata_q;
      OP_RS:   wr_val = old_q | wdata_q;
      OP_RC:   wr_val = old_q & ~wdata_q;
      default: wr_val = old_q;
    endcase
  end

  // Next-state logic: one state per enabled cycle, RESP waits for consumer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else if (clk_en_i) begin
      state <= state_nxt;
    end
  end

  // Request latch, read capture, response registers and arbitration pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      src_q       <= 1'b0;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      rd_ill_q    <= 1'b0;
      last_dbg_q  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_src_o   <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_exc_o   <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        src_q      <= grant_dbg;
        op_q       <= grant_dbg ? dbg_op_i    : core_op_i;
        addr_q     <= grant_dbg ? dbg_addr_i  : core_addr_i;
        wdata_q    <= grant_dbg ? dbg_wdata_i : core_wdata_i;
        last_dbg_q <= grant_dbg;
      end
      if (state == S_READ) begin
        old_q    <= csr_rd_data_i;
        rd_ill_q <= csr_illegal_rd_i;
      end
      if (state == S_WRITE) begin
        rsp_valid_o <= 1'b1;
        rsp_src_o   <= src_q;
        rsp_exc_o   <= exc_nxt;
        rsp_rdata_o <= exc_nxt ? '0 : old_q;
      end
      if ((state == S_RESP) && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule
